vpe_result_drain: RTL and testbench
===================================

// Module: vpe_result_drain
// PURPOSE
//  Consumer end of the VPE result interface. Captures one full VPE result set (PIPE_STAGE
//  lanes of vector + scalar + mode) per handshake. Serialises it onto a narrow ready/valid
//  beat stream toward the result writer / scratchpad. Vector-mode lanes emit TILE_SIZE/BEAT_ELEMS
//  beats; scalar-mode lanes emit one beat. Sits directly behind VPE Vec_o/Scal_o.
// PARAMETERS
//  PIPE_STAGE  2    lanes per result set (matches VPE)
//  TILE_SIZE   128  elements per vector lane
//  MUL_WIDTH   16   bits per element / scalar
//  BEAT_ELEMS  16   elements per output beat; must divide TILE_SIZE (NBEATS=TILE_SIZE/BEAT_ELEMS)
// PORTS
//  clk_i        in   1                            clock, all state on rising edge
//  rst_i        in   1                            async reset, active-high
//  res_valid_i  in   1                            result set valid
//  res_ready_o  out  1                            drain can capture a result set
//  res_vec_i    in   PIPE_STAGE*TILE_SIZE*MUL_WIDTH   per-lane vector (VPE Vec_o)
//  res_scal_i   in   PIPE_STAGE*MUL_WIDTH         per-lane scalar (VPE Scal_o)
//  res_mode_i   in   PIPE_STAGE                   per-lane mode, 1=scalar 0=vector
//  out_valid_o  out  1                            beat valid
//  out_ready_i  in   1                            downstream accepts beat
//  out_data_o   out  BEAT_ELEMS*MUL_WIDTH         beat payload, element 0 in LSBs
//  out_lane_o   out  $clog2(PIPE_STAGE)           lane of current beat
//  out_beat_o   out  $clog2(NBEATS)               beat index within lane
//  out_last_o   out  1                            last beat of current lane
//  out_end_o    out  1                            last beat of the result set
// BEHAVIOUR
//  - FSM: IDLE, SEND. Reset -> IDLE; lane_cnt=0, beat_cnt=0, holding regs=0,
//    out_valid_o=0, out_data_o=0, all out_* flags 0, res_ready_o=1 once out of reset.
//  - Capture fire = res_valid_i & res_ready_o: latch vec/scal/mode into holding regs,
//    lane_cnt=0, beat_cnt=0, go SEND. out_valid_o high the cycle after capture (1-cycle latency).
//  - SEND: out_valid_o=1; payload stable while out_valid_o & !out_ready_i.
//    Vector lane: out_data_o = vec[lane][beat_cnt*BEAT_ELEMS +: BEAT_ELEMS].
//    Scalar lane: out_data_o = {zeros, scal[lane]}, single beat, out_beat_o=0.
//  - out_last_o = scalar lane, or beat_cnt==NBEATS-1. out_end_o = out_last_o & lane_cnt==PIPE_STAGE-1.
//  - Beat fire (out_valid_o & out_ready_i): !last -> beat_cnt++; last & !end -> lane_cnt++, beat_cnt=0;
//    end -> beat_cnt=0, lane_cnt=0, go IDLE unless simultaneous capture.
//  - res_ready_o = (state==IDLE) | (beat fire & out_end_o). Back-to-back: capture in the same
//    cycle as the end beat -> SEND continues with the new set, no bubble, lane 0 beat 0 next cycle.
//  - No capture in SEND except on the end beat; res_valid_i held by upstream.
//  - Mode bits change nothing mid-set; they are sampled only at capture.
//  - Async reset mid-set: set is dropped, FSM IDLE, out_valid_o=0 immediately.
//  - Counters never wrap past NBEATS-1 / PIPE_STAGE-1; no data dropped or duplicated.
// CONFIGURATION
//  VPE_DRAIN_PARITY_EN defined: extra port out_parity_o out 1 = XOR-reduce of out_data_o,
//   registered with the beat, reset 0, stable under backpressure.
//  Not defined: port absent, no parity logic; all other behaviour identical.
// TESTING
//  - Reset: assert rst_i mid-SEND -> out_valid_o=0 same cycle, res_ready_o=1 after release.
//  - All-vector set, mode=2'b00, vec[l][e]=l*256+e, out_ready_i=1 -> 16 beats, beat k of lane l
//    element 0 = l*256+k*16; out_last_o on beats 7,15; out_end_o only on beat 15.
//  - Mixed mode=2'b01, scal[0]=16'h3C00 -> lane0 one beat data=16'h3C00 zero-padded, last=1;
//    lane1 8 vector beats; 9 beats total.
//  - Backpressure: out_ready_i random 50% -> beats in order, payload/lane/beat stable while stalled.
//  - Back-to-back: res_valid_i held high with 3 sets, out_ready_i=1 -> capture on every end
//    beat, no idle cycle between sets (mode=2'b11 -> exactly 2 beats per set).
//  - VPE_DRAIN_PARITY_EN: beat data 16'h0001 in lane 0, rest 0 -> out_parity_o=1; all-zero -> 0.

Source files
------------

// File: rtl/vpe_result_drain.sv
// vpe_result_drain
//   Consumer end of the VPE result interface. Captures one full result set
//   (PIPE_STAGE lanes of vector + scalar + mode) per handshake and serialises
//   it onto a narrow ready/valid beat stream. Vector lanes emit
//   TILE_SIZE/BEAT_ELEMS beats, scalar lanes emit a single zero-padded beat.
//   All out_* signals are registered. The next beat is computed from the
//   holding registers, or from the inputs directly on a capture cycle. This
//   lets a newly captured set start with no bubble.
//   Optional feature macro: VPE_DRAIN_PARITY_EN adds out_parity_o, the
//   XOR-reduce of out_data_o registered alongside the beat.
module vpe_result_drain #(
    parameter int  PIPE_STAGE = 2,
    parameter int  TILE_SIZE  = 128,
    parameter int  MUL_WIDTH  = 16,
    parameter int  BEAT_ELEMS = 16,
    localparam int NBEATS     = TILE_SIZE / BEAT_ELEMS,
    localparam int LANE_W     = (PIPE_STAGE > 1) ? $clog2(PIPE_STAGE) : 1,
    localparam int BEAT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      res_valid_i,
    output logic                                      res_ready_o,
    input  logic [PIPE_STAGE*TILE_SIZE*MUL_WIDTH-1:0] res_vec_i,
    input  logic [PIPE_STAGE*MUL_WIDTH-1:0]           res_scal_i,
    input  logic [PIPE_STAGE-1:0]                     res_mode_i,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [BEAT_ELEMS*MUL_WIDTH-1:0]           out_data_o,
    output logic [LANE_W-1:0]                         out_lane_o,
    output logic [BEAT_W-1:0]                         out_beat_o,
    output logic                                      out_last_o,
    output logic                                      out_end_o
`ifdef VPE_DRAIN_PARITY_EN
    ,
    output logic                                      out_parity_o
`endif
);

    localparam int VEC_W      = PIPE_STAGE * TILE_SIZE * MUL_WIDTH;
    localparam int SCAL_W     = PIPE_STAGE * MUL_WIDTH;
    localparam int LANE_VEC_W = TILE_SIZE * MUL_WIDTH;
    localparam int BEAT_DW    = BEAT_ELEMS * MUL_WIDTH;

    localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEATS - 1);
    localparam logic [LANE_W-1:0] LANE_ZERO = LANE_W'(0);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIPE_STAGE - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;

    logic [VEC_W-1:0]        vec_r;
    logic [SCAL_W-1:0]       scal_r;
    logic [PIPE_STAGE-1:0]   mode_r;

    logic                    out_valid_r;
    logic [BEAT_DW-1:0]      out_data_r;
    logic [LANE_W-1:0]       lane_cnt_r;
    logic [BEAT_W-1:0]       beat_cnt_r;
    logic                    out_last_r;
    logic                    out_end_r;

    logic                    beat_fire_s;
    logic                    res_ready_s;
    logic                    cap_s;
    logic                    load_s;
    logic                    drop_s;

    logic [LANE_W-1:0]       lane_nxt_s;
    logic [BEAT_W-1:0]       beat_nxt_s;
    logic [VEC_W-1:0]        src_vec_s;
    logic [SCAL_W-1:0]       src_scal_s;
    logic [PIPE_STAGE-1:0]   src_mode_s;
    logic [BEAT_DW-1:0]      data_nxt_s;
    logic                    last_nxt_s;
    logic                    end_nxt_s;

    // Handshake qualifiers. A capture is only possible while idle or on the
    // accepted end beat; load_s means a new beat enters the output registers.
    assign beat_fire_s = out_valid_r & out_ready_i;
    assign res_ready_s = (state_r == ST_IDLE) | (beat_fire_s & out_end_r);
    assign cap_s       = res_valid_i & res_ready_s;
    assign load_s      = cap_s | (beat_fire_s & ~out_end_r);
    assign drop_s      = beat_fire_s & out_end_r & ~cap_s;

    // Next-state logic: leave SEND only when the end beat goes without a new capture.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cap_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (drop_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next lane/beat position: restart on capture, step through beats then lanes.
    always_comb begin
        lane_nxt_s = lane_cnt_r;
        beat_nxt_s = beat_cnt_r;
        if (cap_s) begin
            lane_nxt_s = LANE_ZERO;
            beat_nxt_s = BEAT_ZERO;
        end else if (beat_fire_s) begin
            if (!out_last_r) begin
                beat_nxt_s = beat_cnt_r + BEAT_ONE;
            end else if (!out_end_r) begin
                lane_nxt_s = lane_cnt_r + LANE_ONE;
                beat_nxt_s = BEAT_ZERO;
            end else begin
                lane_nxt_s = LANE_ZERO;
                beat_nxt_s = BEAT_ZERO;
            end
        end else begin
            lane_nxt_s = lane_cnt_r;
            beat_nxt_s = beat_cnt_r;
        end
    end

    // Source of the next beat: fresh inputs on a capture, holding registers otherwise.
    always_comb begin
        src_vec_s  = vec_r;
        src_scal_s = scal_r;
        src_mode_s = mode_r;
        if (cap_s) begin
            src_vec_s  = res_vec_i;
            src_scal_s = res_scal_i;
            src_mode_s = res_mode_i;
        end else begin
            src_vec_s  = vec_r;
            src_scal_s = scal_r;
            src_mode_s = mode_r;
        end
    end

    // Payload and framing flags of the next beat.
    always_comb begin
        data_nxt_s = {BEAT_DW{1'b0}};
        if (src_mode_s[lane_nxt_s]) begin
            data_nxt_s = {{(BEAT_DW - MUL_WIDTH){1'b0}},
                          src_scal_s[int'(lane_nxt_s) * MUL_WIDTH +: MUL_WIDTH]};
        end else begin
            data_nxt_s = src_vec_s[int'(lane_nxt_s) * LANE_VEC_W +
                                   int'(beat_nxt_s) * BEAT_DW +: BEAT_DW];
        end
        last_nxt_s = src_mode_s[lane_nxt_s] | (beat_nxt_s == BEAT_LAST);
        end_nxt_s  = last_nxt_s & (lane_nxt_s == LANE_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Holding registers: sampled only at capture, so mid-set input changes are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vec_r  <= {VEC_W{1'b0}};
            scal_r <= {SCAL_W{1'b0}};
            mode_r <= {PIPE_STAGE{1'b0}};
        end else if (cap_s) begin
            vec_r  <= res_vec_i;
            scal_r <= res_scal_i;
            mode_r <= res_mode_i;
        end else begin
            vec_r  <= vec_r;
            scal_r <= scal_r;
            mode_r <= mode_r;
        end
    end

    // Output beat registers: load the next beat, clear after the last accepted beat, else hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {BEAT_DW{1'b0}};
            lane_cnt_r  <= LANE_ZERO;
            beat_cnt_r  <= BEAT_ZERO;
            out_last_r  <= 1'b0;
            out_end_r   <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= data_nxt_s;
            lane_cnt_r  <= lane_nxt_s;
            beat_cnt_r  <= beat_nxt_s;
            out_last_r  <= last_nxt_s;
            out_end_r   <= end_nxt_s;
        end else if (drop_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {BEAT_DW{1'b0}};
            lane_cnt_r  <= LANE_ZERO;
            beat_cnt_r  <= BEAT_ZERO;
            out_last_r  <= 1'b0;
            out_end_r   <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            lane_cnt_r  <= lane_cnt_r;
            beat_cnt_r  <= beat_cnt_r;
            out_last_r  <= out_last_r;
            out_end_r   <= out_end_r;
        end
    end

`ifdef VPE_DRAIN_PARITY_EN
    logic out_parity_r;

    function automatic logic parity_f(input logic [BEAT_DW-1:0] data);
        return ^data;
    endfunction

    // Parity register: tracks the beat register exactly, so it is stable under backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_parity_r <= 1'b0;
        end else if (load_s) begin
            out_parity_r <= parity_f(data_nxt_s);
        end else if (drop_s) begin
            out_parity_r <= 1'b0;
        end else begin
            out_parity_r <= out_parity_r;
        end
    end

    assign out_parity_o = out_parity_r;
`endif

    assign res_ready_o = res_ready_s;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign out_lane_o  = lane_cnt_r;
    assign out_beat_o  = beat_cnt_r;
    assign out_last_o  = out_last_r;
    assign out_end_o   = out_end_r;

endmodule

// File: tb/tb_vpe_result_drain.sv
// tb_vpe_result_drain
//   Directed bench for vpe_result_drain with default parameters
//   (2 lanes, 128 x 16-bit elements, 16 elements per beat -> 8 beats/lane).
//   Optional feature macro: VPE_DRAIN_PARITY_EN (parity port and checks).
module tb_vpe_result_drain;

    localparam int PS = 2;
    localparam int TS = 128;
    localparam int MW = 16;
    localparam int BE = 16;
    localparam int NB = TS / BE;

    logic                  clk_i;
    logic                  rst_i;
    logic                  res_valid_i;
    logic                  res_ready_o;
    logic [PS*TS*MW-1:0]   res_vec_i;
    logic [PS*MW-1:0]      res_scal_i;
    logic [PS-1:0]         res_mode_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [BE*MW-1:0]      out_data_o;
    logic [0:0]            out_lane_o;
    logic [2:0]            out_beat_o;
    logic                  out_last_o;
    logic                  out_end_o;
`ifdef VPE_DRAIN_PARITY_EN
    logic                  out_parity_o;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    vpe_result_drain dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .res_valid_i (res_valid_i),
        .res_ready_o (res_ready_o),
        .res_vec_i   (res_vec_i),
        .res_scal_i  (res_scal_i),
        .res_mode_i  (res_mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_lane_o  (out_lane_o),
        .out_beat_o  (out_beat_o),
        .out_last_o  (out_last_o),
        .out_end_o   (out_end_o)
`ifdef VPE_DRAIN_PARITY_EN
        ,
        .out_parity_o(out_parity_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // vec[l][e] = base + l*256 + e
    task automatic set_vec(input int base);
        for (int l = 0; l < PS; l++) begin
            for (int e = 0; e < TS; e++) begin
                res_vec_i[(l*TS + e)*MW +: MW] = 16'(base + l*256 + e);
            end
        end
    endtask

    function automatic logic [255:0] exp_beat(input int base, input int l, input int k);
        logic [255:0] d;
        d = 256'd0;
        for (int e = 0; e < BE; e++) begin
            d[e*MW +: MW] = 16'(base + l*256 + k*BE + e);
        end
        return d;
    endfunction

    task automatic chk_beat(input string tag, input int l, input int k,
                            input logic [255:0] d, input bit last, input bit fin);
        chk($sformatf("%s valid l%0d b%0d", tag, l, k), 256'(out_valid_o), 256'(1'b1));
        chk($sformatf("%s lane l%0d b%0d",  tag, l, k), 256'(out_lane_o),  256'(l));
        chk($sformatf("%s beat l%0d b%0d",  tag, l, k), 256'(out_beat_o),  256'(k));
        chk($sformatf("%s data l%0d b%0d",  tag, l, k), out_data_o,        d);
        chk($sformatf("%s last l%0d b%0d",  tag, l, k), 256'(out_last_o),  256'(last));
        chk($sformatf("%s end l%0d b%0d",   tag, l, k), 256'(out_end_o),   256'(fin));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  l;
        int  k;
        bit  fire;
        bit  done;
        int  v;

        // ---------------- reset ----------------
        rst_i       = 1'b1;
        res_valid_i = 1'b0;
        res_vec_i   = '0;
        res_scal_i  = '0;
        res_mode_i  = 2'b00;
        out_ready_i = 1'b0;
        repeat (3) step();
        chk("rst_valid_in_reset", 256'(out_valid_o), 256'(1'b0));
        rst_i = 1'b0;
        step();
        chk("rst_ready", 256'(res_ready_o), 256'(1'b1));
        chk("rst_valid", 256'(out_valid_o), 256'(1'b0));
        chk("rst_data",  out_data_o,        256'd0);
        chk("rst_lane",  256'(out_lane_o),  256'd0);
        chk("rst_beat",  256'(out_beat_o),  256'd0);
        chk("rst_last",  256'(out_last_o),  256'(1'b0));
        chk("rst_end",   256'(out_end_o),   256'(1'b0));
`ifdef VPE_DRAIN_PARITY_EN
        chk("rst_parity", 256'(out_parity_o), 256'(1'b0));
`endif

        // ---------------- all-vector set ----------------
        set_vec(0);
        res_mode_i  = 2'b00;
        res_valid_i = 1'b1;
        out_ready_i = 1'b1;
        step();
        res_valid_i = 1'b0;
        for (int ll = 0; ll < PS; ll++) begin
            for (int kk = 0; kk < NB; kk++) begin
                chk_beat("vec", ll, kk, exp_beat(0, ll, kk), kk == NB-1, (ll == PS-1) && (kk == NB-1));
                step();
            end
        end
        chk("vec_idle_valid", 256'(out_valid_o), 256'(1'b0));
        chk("vec_idle_ready", 256'(res_ready_o), 256'(1'b1));

        // ---------------- mixed: lane0 scalar, lane1 vector ----------------
        res_scal_i  = {16'h1234, 16'h3C00};
        res_mode_i  = 2'b01;
        res_valid_i = 1'b1;
        step();
        res_valid_i = 1'b0;
        chk_beat("mix_scal", 0, 0, 256'h3C00, 1'b1, 1'b0);
        step();
        for (int kk = 0; kk < NB; kk++) begin
            chk_beat("mix_vec", 1, kk, exp_beat(0, 1, kk), kk == NB-1, kk == NB-1);
            step();
        end
        chk("mix_9beats_idle", 256'(out_valid_o), 256'(1'b0));

        // ---------------- backpressure ----------------
        set_vec(32'h4000);
        res_mode_i  = 2'b00;
        res_valid_i = 1'b1;
        out_ready_i = 1'b0;
        step();
        res_valid_i = 1'b0;
        res_mode_i  = 2'b11;   // must be ignored mid-set
        l    = 0;
        k    = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            out_ready_i = 1'($urandom_range(0, 1));
            chk_beat("bp", l, k, exp_beat(32'h4000, l, k), k == NB-1, (l == PS-1) && (k == NB-1));
            fire = out_ready_i & out_valid_o;
            step();
            if (fire) begin
                if (k == NB-1) begin
                    if (l == PS-1) begin
                        done = 1'b1;
                    end else begin
                        l = l + 1;
                        k = 0;
                    end
                end else begin
                    k = k + 1;
                end
            end
        end
        chk("bp_done", 256'(done), 256'(1'b1));
        chk("bp_idle_valid", 256'(out_valid_o), 256'(1'b0));
        out_ready_i = 1'b1;

        // ---------------- back-to-back, all-scalar sets ----------------
        res_mode_i  = 2'b11;
        res_scal_i  = {16'h2001, 16'h2000};
        res_valid_i = 1'b1;
        step();
        for (int s = 0; s < 3; s++) begin
            if (s < 2) begin
                v = 32'h2000 + (s + 1) * 16;
                res_scal_i = {16'(v + 1), 16'(v)};
            end else begin
                res_valid_i = 1'b0;
            end
            v = 32'h2000 + s * 16;
            chk_beat($sformatf("b2b s%0d", s), 0, 0, 256'(v), 1'b1, 1'b0);
            chk($sformatf("b2b ready_mid s%0d", s), 256'(res_ready_o), 256'(1'b0));
            step();
            chk_beat($sformatf("b2b s%0d", s), 1, 0, 256'(v + 1), 1'b1, 1'b1);
            chk($sformatf("b2b ready_end s%0d", s), 256'(res_ready_o), 256'(1'b1));
            step();
        end
        chk("b2b_idle_valid", 256'(out_valid_o), 256'(1'b0));

        // ---------------- async reset mid-set ----------------
        set_vec(0);
        res_mode_i  = 2'b00;
        res_valid_i = 1'b1;
        step();
        res_valid_i = 1'b0;
        step();
        step();
        chk("mrst_pre_beat", 256'(out_beat_o), 256'd2);
        rst_i = 1'b1;
        #1;
        chk("mrst_valid_now", 256'(out_valid_o), 256'(1'b0));
        step();
        rst_i = 1'b0;
        step();
        chk("mrst_ready", 256'(res_ready_o), 256'(1'b1));
        chk("mrst_valid", 256'(out_valid_o), 256'(1'b0));
        chk("mrst_lane",  256'(out_lane_o),  256'd0);
        chk("mrst_beat",  256'(out_beat_o),  256'd0);
        chk("mrst_data",  out_data_o,        256'd0);

`ifdef VPE_DRAIN_PARITY_EN
        // ---------------- parity ----------------
        res_vec_i      = '0;
        res_vec_i[0]   = 1'b1;
        res_mode_i     = 2'b00;
        res_valid_i    = 1'b1;
        step();
        res_valid_i = 1'b0;
        chk("par_beat0_data", out_data_o, 256'h1);
        chk("par_beat0", 256'(out_parity_o), 256'(1'b1));
        out_ready_i = 1'b0;
        step();
        chk("par_stall", 256'(out_parity_o), 256'(1'b1));
        out_ready_i = 1'b1;
        step();
        chk("par_beat1", 256'(out_parity_o), 256'(1'b0));
        repeat (2*NB - 1) step();
        chk("par_idle_valid", 256'(out_valid_o), 256'(1'b0));
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
